pezaris_cpa_stage: RTL
======================

Name: pezaris_cpa_stage

Overview:
- Final carry-propagate stage of the Pezaris two's-complement array multiplier.
- Sits directly downstream of the last U-generation row. It takes that row's sum vector u and carry vector c, plus the low product bits already resolved by earlier rows, and produces the full 2W-bit product.
- Two-stage pipeline: carry is split at LO_W. Full valid/ready handshake; registered outputs.

Parameters:
- W, 7, operand width; width of u, c, p_lo and of the high product half.
- LO_W, 4, bits resolved in pipeline stage 1; stage 2 resolves bits W-1:LO_W. Legal range 1..W-1.
- CORR, 0, W-bit constant added into the high half (sign-correction term, set at integration).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  u/c/p_lo valid this cycle
- in_ready  out  1  stage can accept input
- u  in  W  sum vector from last U row
- c  in  W  carry vector from last U row (weight 2^(i+1))
- p_lo  in  W  product bits W-1:0, passed through
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- p  out  2W  product {hi, p_lo}

Behaviour:
- Arithmetic: hi = (u + {c[W-2:0],1'b0} + CORR) mod 2^W. c[W-1] is discarded. p = {hi, p_lo}.
- Stage 1 (S1):
  - Registers lo_sum = u[LO_W-1:0] + {c[LO_W-2:0],1'b0} + CORR[LO_W-1:0], keeping the LO_W-bit result and carry-out k.
  - Registers the upper operand slices u[W-1:LO_W], c[W-2:LO_W-1], CORR[W-1:LO_W], and p_lo.
- Stage 2 (S2): registers hi = {upper slice sum + k, lo_sum} and drives p from its register.
- Latency: exactly 2 cycles from the accepted input (in_valid & in_ready) to out_valid when out_ready is held high. Throughput is 1 per cycle.
- Handshake:
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - S2 loads when S2 is empty or out_ready.
  - S1 advances when S1 is valid and S2 can load.
  - in_ready = !S1_valid | S2_can_load. This is combinational from out_ready; no skid buffer.
  - While out_valid & !out_ready, p and out_valid stay stable.
  - Transfers are never dropped or duplicated.
- Stall and fill:
  - With both stages full and out_ready low, in_ready is 0.
  - When out_ready rises, in_ready goes to 1 in the same cycle and both stages shift.
- Simultaneous events: an output transfer and an input transfer in the same cycle are both honoured.
- Reset (rst high at a clock edge, including mid-stall):
  - S1_valid = 0, S2_valid = 0, out_valid = 0, p = 0. Data registers are also cleared to 0.
  - in_ready reads 1 in the first cycle after reset.
  - Any in-flight products are discarded.
- Wrap: high-half overflow is silently truncated mod 2^W. There is no overflow flag.
- Data registers load only on an accepted transfer into their stage. Bubbles do not corrupt held data.

Decomposition:
- Shared package pezaris_pkg:
  - Constants W and LO_W defaults.
  - CORR default.
  - product_t type (2W bits).
  - Shared with the U-row stages.
- One natural sub-module: pezaris_pipe_ctl, the 2-entry valid/ready pipeline control. It produces the per-stage load enables and in_ready/out_valid.
- The adders are inline behavioural additions; no reuse of the full-adder cells.

Test Plan:
- Basic: W=7, LO_W=4, CORR=0; u=7'h05, c=7'h03, p_lo=7'h2A, out_ready=1 -> 2 cycles later p=14'h05AA (hi=0x0B) with out_valid high for 1 cycle.
- Split carry: u=7'h0F, c=7'h01 -> lo nibble 0x1 with k=1; hi=0x11, p={7'h11, p_lo}.
- Wrap: u=7'h7F, c=7'h01 -> hi=7'h01. Also c=7'h40 with u=0 -> c[6] dropped, hi=0x00.
- Backpressure: stream 4 inputs back-to-back with out_ready=0 for 5 cycles.
  - Required: in_ready drops after 2 accepts.
  - Required: p holds the first result stable.
  - Required: after out_ready=1, all 4 results emerge in order, no loss or duplication.
- Reset mid-operation: 2 products in flight, assert rst for 1 cycle -> next cycle out_valid=0, p=0, in_ready=1. No stale product appears afterwards.
- Random: 10k random u/c/p_lo with random in_valid/out_ready against the reference model p = {(u+(c<<1)+CORR) mod 2^W, p_lo}. Repeat with CORR=7'h40.

Source files
------------

// File: rtl/pezaris_pkg.sv
// Shared definitions for the Pezaris two's-complement array multiplier.
// Used by the U-row stages and the final carry-propagate stage.
package pezaris_pkg;

    localparam int DEF_W    = 7;
    localparam int DEF_LO_W = 4;
    localparam logic [DEF_W-1:0] DEF_CORR = '0;

    typedef logic [2*DEF_W-1:0] product_t;

endpackage

// File: rtl/pezaris_cpa_stage_pipe_ctl.sv
// Valid/ready control for the two-entry carry-propagate pipeline.
// Produces per-stage load enables; in_ready is combinational from out_ready.
module pezaris_pipe_ctl (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic s1_load,
    output logic s2_load
);

    logic s1_valid;
    logic s2_valid;
    logic s2_can_load;

    always_comb begin
        s2_can_load = !s2_valid || out_ready;
        in_ready    = !s1_valid || s2_can_load;
        s1_load     = in_valid && in_ready;
        s2_load     = s1_valid && s2_can_load;
        out_valid   = s2_valid;
    end

    // S1 is refilled (or emptied) whenever it can accept; S2 likewise from S1.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s2_can_load) begin
                s2_valid <= s1_valid;
            end
        end
    end

endmodule

// File: rtl/pezaris_cpa_stage.sv
// Final carry-propagate stage: resolves hi = u + (c << 1) + CORR in two
// pipelined halves split at LO_W and emits the product {hi, p_lo}.
module pezaris_cpa_stage
    import pezaris_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int LO_W = DEF_LO_W,
    parameter logic [W-1:0] CORR = W'(DEF_CORR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     u,
    input  logic [W-1:0]     c,
    input  logic [W-1:0]     p_lo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   p
);

    localparam int HI_W = W - LO_W;

    logic s1_load;
    logic s2_load;

    logic [LO_W-1:0] c_lo_sh;
    logic [LO_W+1:0] lo_full;

    logic [LO_W-1:0] lo_sum_q;
    logic [1:0]      k_q;
    logic [HI_W-1:0] u_hi_q;
    logic [HI_W-1:0] c_hi_q;
    logic [HI_W-1:0] corr_hi_q;
    logic [W-1:0]    p_lo_q;
    logic [HI_W-1:0] hi_up;
    logic [2*W-1:0]  p_q;

    pezaris_pipe_ctl u_ctl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .s1_load   (s1_load),
        .s2_load   (s2_load)
    );

    // With a non-zero CORR three LO_W-bit terms can carry out by up to 2,
    // so the carry into the upper half is kept two bits wide.
    always_comb begin
        c_lo_sh = LO_W'({c, 1'b0});
        lo_full = (LO_W+2)'(u[LO_W-1:0]) + (LO_W+2)'(c_lo_sh)
                + (LO_W+2)'(CORR[LO_W-1:0]);
        hi_up   = u_hi_q + c_hi_q + corr_hi_q + HI_W'(k_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_sum_q  <= '0;
            k_q       <= '0;
            u_hi_q    <= '0;
            c_hi_q    <= '0;
            corr_hi_q <= '0;
            p_lo_q    <= '0;
        end else if (s1_load) begin
            lo_sum_q  <= lo_full[LO_W-1:0];
            k_q       <= lo_full[LO_W+1:LO_W];
            u_hi_q    <= u[W-1:LO_W];
            c_hi_q    <= c[W-2:LO_W-1];
            corr_hi_q <= CORR[W-1:LO_W];
            p_lo_q    <= p_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
        end else if (s2_load) begin
            p_q <= {hi_up, lo_sum_q, p_lo_q};
        end
    end

    assign p = p_q;

endmodule
